pipeline_hazard_controller: RTL

- Sequencing controller for the decode stage of the 5-stage ARM pipeline.
- Keeps a two-entry scoreboard of in-flight instructions (EXE, MEM) and drives the decode stage's hazard input.
- Generates IF/ID freeze, branch flush and a global freeze while the memory stage waits on external SRAM.
- Runs a stall counter and a memory-timeout error state.

---
 rtl/arm_pipe_pkg.sv | 15 +
 rtl/hazard_compare.sv | 15 +
 rtl/pipeline_hazard_controller.sv | 112 +++++++++++
 3 files changed

// File: rtl/arm_pipe_pkg.sv
// Shared types for the ARM decode-stage hazard controller.
package arm_pipe_pkg;
   localparam int REG_W = 4;

   typedef enum logic [1:0] {RUN, WAIT, ERROR} state_e;

   // One in-flight instruction as seen by the decode-stage scoreboard.
   typedef struct packed {
      logic             valid;
      logic             wb_en;
      logic             mem_r_en;
      logic             mem_w_en;
      logic [REG_W-1:0] dest;
   } sb_entry_t;
endpackage

// File: rtl/hazard_compare.sv
// RAW comparison of one scoreboard entry against the ID-stage source registers.
module hazard_compare
   import arm_pipe_pkg::*;
(
   input  sb_entry_t        entry,
   input  logic [REG_W-1:0] src1,
   input  logic [REG_W-1:0] src2,
   input  logic             two_src,
   output logic             raw_match,
   output logic             load_match
);
   assign raw_match  = entry.valid & entry.wb_en &
                       ((entry.dest == src1) | (two_src & (entry.dest == src2)));
   assign load_match = raw_match & entry.mem_r_en;
endmodule

// File: rtl/pipeline_hazard_controller.sv
// Decode-stage sequencing: EXE/MEM scoreboard, RAW stall, branch flush and
// SRAM-wait freeze with a timeout error state.
module pipeline_hazard_controller
   import arm_pipe_pkg::*;
#(
   parameter bit FORWARD_EN  = 1'b0,
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] src1,
   input  logic [REG_W-1:0] src2,
   input  logic             two_src,
   input  logic             id_valid,
   input  logic             id_wb_en,
   input  logic             id_mem_r_en,
   input  logic             id_mem_w_en,
   input  logic [REG_W-1:0] id_dest,
   input  logic             branch_taken,
   input  logic             mem_ready,
   output logic             hazard,
   output logic             freeze_if,
   output logic             flush,
   output logic             freeze_all,
   output logic             mem_error,
   output logic [CNT_W-1:0] stall_count
);
   localparam int WCNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

   sb_entry_t         exe_q, mem_q, exe_d;
   state_e            state_q, state_d;
   logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0]  stall_cnt_q;
   logic              exe_raw, exe_load, mem_raw, mem_load_unused;
   logic              hazard_raw, mem_busy;

   hazard_compare u_cmp_exe (
      .entry(exe_q), .src1(src1), .src2(src2), .two_src(two_src),
      .raw_match(exe_raw), .load_match(exe_load)
   );

   hazard_compare u_cmp_mem (
      .entry(mem_q), .src1(src1), .src2(src2), .two_src(two_src),
      .raw_match(mem_raw), .load_match(mem_load_unused)
   );

   // With forwarding only a load in EXE cannot be bypassed in time.
   assign hazard_raw = FORWARD_EN ? exe_load : (exe_raw | mem_raw);
   assign mem_busy   = mem_q.valid & (mem_q.mem_r_en | mem_q.mem_w_en) & ~mem_ready;

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      freeze_all = 1'b0;
      mem_error  = 1'b0;
      case (state_q)
         RUN: if (mem_busy) begin
            freeze_all = 1'b1;
            // The entry cycle already counts as one mem_ready-low cycle.
            wait_cnt_d = WCNT_W'(1);
            state_d    = (MEM_TIMEOUT > 1) ? WAIT : ERROR;
         end
         WAIT: if (mem_ready) begin
            wait_cnt_d = '0;
            state_d    = RUN;
         end else begin
            freeze_all = 1'b1;
            if (wait_cnt_q == WCNT_W'(MEM_TIMEOUT - 1)) state_d = ERROR;
            else wait_cnt_d = wait_cnt_q + 1'b1;
         end
         ERROR: begin
            freeze_all = 1'b1;
            mem_error  = 1'b1;
         end
         default: state_d = RUN;
      endcase
   end

   assign flush       = branch_taken & ~freeze_all & ~rst;
   assign hazard      = hazard_raw & id_valid & ~flush & ~freeze_all & ~rst;
   assign freeze_if   = hazard;
   assign stall_count = stall_cnt_q;

   always_comb begin
      exe_d          = '0;
      exe_d.valid    = id_valid & ~hazard_raw & ~flush;
      exe_d.wb_en    = id_wb_en;
      exe_d.mem_r_en = id_mem_r_en;
      exe_d.mem_w_en = id_mem_w_en;
      exe_d.dest     = id_dest;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exe_q       <= '0;
         mem_q       <= '0;
         state_q     <= RUN;
         wait_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         if (!freeze_all) begin
            mem_q <= exe_q;
            exe_q <= exe_d;
         end
         if ((hazard | freeze_all) && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + 1'b1;
      end
   end
endmodule
